// File: rtl/resource_arbiter.sv
// Round-robin arbiter sharing one combinational resource between NUM_REQ pipelines.
// Optional macro ARB_QUANTUM_EN limits an owner to QUANTUM consecutive grant cycles under contention.
module resource_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned QUANTUM = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic                     flush,
  output logic [NUM_REQ-1:0]       grant,
  output logic [WIDTH-1:0]         res_in,
  output logic                     res_in_valid,
  input  logic [WIDTH-1:0]         res_out,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic                     busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_next;
  logic [NUM_REQ-1:0]   grant_next;
  logic [IDX_W-1:0]     last_owner, last_owner_next;
  logic [IDX_W-1:0]     tag;
  logic [NUM_REQ-1:0]   others;
  logic                 xfer;

`ifdef ARB_QUANTUM_EN
  localparam int unsigned CNT_W = $clog2(QUANTUM + 1);
  logic [CNT_W-1:0] qcnt, qcnt_next;
`endif

  // First set bit of mask at or after index start, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                               input int unsigned start);
    logic found;
    int unsigned idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (start + i) % NUM_REQ;
      if (!found && mask[idx]) begin
        rr_pick = IDX_W'(idx);
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  assign others = req & ~grant;
  assign xfer   = |(grant & req);

  always_comb begin
    logic [IDX_W-1:0] pick;
    state_next      = state;
    grant_next      = grant;
    last_owner_next = last_owner;
    pick            = '0;
`ifdef ARB_QUANTUM_EN
    qcnt_next       = qcnt;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          pick            = rr_pick(req, int'(last_owner) + 1);
          grant_next      = onehot(pick);
          last_owner_next = pick;
          state_next      = GRANT;
`ifdef ARB_QUANTUM_EN
          qcnt_next       = '0;
`endif
        end
      end
      GRANT: begin
        if (req[last_owner]) begin
`ifdef ARB_QUANTUM_EN
          if (qcnt == CNT_W'(QUANTUM - 1) && (|others)) begin
            pick            = rr_pick(others, int'(last_owner) + 1);
            grant_next      = onehot(pick);
            last_owner_next = pick;
            qcnt_next       = '0;
          end else if (qcnt < CNT_W'(QUANTUM - 1)) begin
            qcnt_next = qcnt + 1'b1;
          end
`endif
        end else if (|others) begin
          // Direct hand-off; last_owner is always the current owner while in GRANT.
          pick            = rr_pick(others, int'(last_owner) + 1);
          grant_next      = onehot(pick);
          last_owner_next = pick;
`ifdef ARB_QUANTUM_EN
          qcnt_next       = '0;
`endif
        end else begin
          grant_next = '0;
          state_next = IDLE;
        end
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_owner   <= IDX_W'(NUM_REQ - 1);
      tag          <= '0;
      res_in       <= '0;
      res_in_valid <= 1'b0;
      rsp_data     <= '0;
      rsp_valid    <= '0;
`ifdef ARB_QUANTUM_EN
      qcnt         <= '0;
`endif
    end else if (flush) begin
      state        <= IDLE;
      grant        <= '0;
      res_in_valid <= 1'b0;
      rsp_valid    <= '0;
`ifdef ARB_QUANTUM_EN
      qcnt         <= '0;
`endif
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_owner <= last_owner_next;
`ifdef ARB_QUANTUM_EN
      qcnt       <= qcnt_next;
`endif
      res_in_valid <= xfer;
      if (xfer) begin
        res_in <= req_data[int'(last_owner)*WIDTH +: WIDTH];
        tag    <= last_owner;
      end
      if (res_in_valid) begin
        rsp_data  <= res_out;
        rsp_valid <= onehot(tag);
      end else begin
        rsp_valid <= '0;
      end
    end
  end

  assign busy = (|grant) | res_in_valid | (|rsp_valid);

endmodule

// File: tb/tb_resource_arbiter.sv
// Directed self-checking bench for resource_arbiter; the shared resource is modelled as res_in + 0x100.
module tb_resource_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int QUANTUM = 8;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic                     flush;
  logic [NUM_REQ-1:0]       grant;
  logic [WIDTH-1:0]         res_in;
  logic                     res_in_valid;
  logic [WIDTH-1:0]         res_out;
  logic [WIDTH-1:0]         rsp_data;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  resource_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .QUANTUM(QUANTUM)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .flush(flush),
    .grant(grant), .res_in(res_in), .res_in_valid(res_in_valid), .res_out(res_out),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .busy(busy)
  );

  assign res_out = res_in + 32'h100;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [5];
    logic [3:0] exp_g;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset = 1'b0; flush = 1'b0; req = '0; req_data = '0;
    tick; tick;
    check("rst_grant", grant, 0);
    check("rst_res_in", res_in, 0);
    check("rst_riv", res_in_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);

    // Single requester latency
    reset = 1'b1; req = 4'b0001; set_data(0, 32'h11);
    tick; check("lat_grant", grant, 4'b0001); check("lat_riv0", res_in_valid, 0);
    tick; check("lat_res_in", res_in, 32'h11); check("lat_riv1", res_in_valid, 1);
    check("lat_rsp0", rsp_valid, 0);
    tick; check("lat_rsp_valid", rsp_valid, 4'b0001); check("lat_rsp_data", rsp_data, 32'h111);
    req = 4'b0000;
    tick; check("lat_idle", grant, 0); check("lat_last_rsp", rsp_valid, 4'b0001);
    tick; check("lat_busy0", busy, 0);

    // Round-robin order with single-cycle grants
    reset = 1'b0; tick; tick; reset = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("rr_grant%0d", i), grant, seq[i]);
      req = 4'b1111 & ~seq[i];
    end
    check("rr_no_rsp", rsp_valid, 0);
    req = 4'b0000;
    tick; tick; tick;

    // Direct hand-off 1 -> 2 with no idle cycle
    req = 4'b0010; set_data(1, 32'h22); set_data(2, 32'h33);
    tick; check("ho_grant1", grant, 4'b0010);
    tick; check("ho_res_in1", res_in, 32'h22);
    req = 4'b0100;
    tick; check("ho_grant2", grant, 4'b0100); check("ho_rsp1", rsp_valid, 4'b0010);
    check("ho_rsp_data1", rsp_data, 32'h122); check("ho_riv_gap", res_in_valid, 0);
    tick; check("ho_grant2_hold", grant, 4'b0100); check("ho_res_in2", res_in, 32'h33);
    check("ho_rsp_gap", rsp_valid, 0);
    tick; check("ho_rsp2", rsp_valid, 4'b0100); check("ho_rsp_data2", rsp_data, 32'h133);
    req = 4'b0000;
    tick; tick; tick;

    // Flush during a transfer; last_owner must survive it
    req = 4'b0010; set_data(1, 32'h44);
    tick; check("fl_grant", grant, 4'b0010);
    tick;
    tick; check("fl_pre_riv", res_in_valid, 1); check("fl_pre_rsp", rsp_valid, 4'b0010);
    flush = 1'b1;
    tick; check("fl_grant0", grant, 0); check("fl_riv0", res_in_valid, 0);
    check("fl_rsp0", rsp_valid, 0); check("fl_busy0", busy, 0);
    flush = 1'b0; req = 4'b0111;
    tick; check("fl_resume_owner", grant, 4'b0100);
    req = 4'b1111;
    tick;
    tick; check("mid_busy", busy, 1); check("mid_rsp", rsp_valid, 4'b0100);

    // Reset mid-stream
    reset = 1'b0;
    tick; check("mr_grant", grant, 0); check("mr_res_in", res_in, 0);
    check("mr_riv", res_in_valid, 0); check("mr_rsp_data", rsp_data, 0);
    check("mr_rsp_valid", rsp_valid, 0); check("mr_busy", busy, 0);
    reset = 1'b1;
    tick; check("mr_first_grant", grant, 4'b0001);

    // Sustained contention: quantum rotation or unlimited hold
    reset = 1'b0; tick; reset = 1'b1; req = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick;
`ifdef ARB_QUANTUM_EN
      exp_g = (((i / QUANTUM) % 2) == 0) ? 4'b0001 : 4'b0010;
`else
      exp_g = 4'b0001;
`endif
      check($sformatf("q_grant%0d", i), grant, exp_g);
    end
    check("q_stream_rsp", rsp_valid != 0, 1);
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      tick;
      check($sformatf("solo_grant%0d", i), grant, 4'b0001);
    end
    req = 4'b0000;
    tick; tick; tick;
    check("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
